ipsmacge_rxpackn: RTL and testbench

Single-clock, parametrised byte-to-word packer for the MAC receive path.
- Packs a DAT_DW-bit framed line stream into MAC_DW-bit words with a byte-count field, frame markers and a frame-accumulated error field.
- Words are buffered in an output FIFO with ready/valid backpressure. Frames that overflow are aborted cleanly. Frames are admitted only if the port is active at start-of-frame.
- Sits between the rx framing stage and the clock-domain converter, on the line clock.

---
 rtl/ipsmacge_rxpackn.sv | 202 ++++++++++++++++++++
 tb/tb_ipsmacge_rxpackn.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsmacge_rxpackn.sv
// rtl/ipsmacge_rxpackn.sv - rx line-to-word packer with abort-safe FWFT output FIFO
// Optional frame/drop counters: define IPSMACGE_RXPACKN_STAT_EN
module ipsmacge_rxpackn #(
    parameter int DAT_DW  = 8,
    parameter int DAT_EW  = 4,
    parameter int MAC_DW  = 32,
    parameter int MAC_BW  = 2,
    parameter int MAC_EW  = 5,
    parameter int FIFO_AW = 3
) (
    input  logic              rxclk,
    input  logic              rxrst_,
    input  logic [DAT_DW-1:0] rx_idat,
    input  logic              rx_ivld,
    input  logic              rx_isop,
    input  logic              rx_ieop,
    input  logic [DAT_EW-1:0] rx_ierr,
    input  logic              upact,
    output logic [MAC_DW-1:0] out_dat,
    output logic [MAC_BW-1:0] out_nob,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              out_sop,
    output logic              out_eop,
    output logic [MAC_EW-1:0] out_err,
    output logic              ovrerr,
    output logic [15:0]       frm_cnt,
    output logic [15:0]       drp_cnt
);
    localparam int LANES = MAC_DW / DAT_DW;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int WW    = 2 + MAC_EW + MAC_BW + MAC_DW;
    localparam int CW    = FIFO_AW + 2;

    typedef enum logic [1:0] {IDLE, PACK, DROP} state_t;

    state_t              state, nxt_state;
    logic [MAC_BW-1:0]   lane, nxt_lane;
    logic [MAC_DW-1:0]   acc, nxt_acc, cur_dat, sop_dat;
    logic [DAT_EW-1:0]   err_acc, nxt_err, new_err;
    logic                sopp, nxt_sopp, start;
    logic                va, vb, ovr, frm_add;
    logic [WW-1:0]       na, nb;
    logic [1:0]          drp_add;
    logic [WW-1:0]       p0, p1, od;
    logic                v0, v1, ov;
    logic [WW-1:0]       mem [DEPTH];
    logic [FIFO_AW-1:0]  wp, rp;
    logic [FIFO_AW:0]    mcnt;
    logic                rd, wr, full, load_out, bypass, mw, mr;
    logic [CW-1:0]       proj;

    function automatic logic [WW-1:0] mkword(input logic s, input logic e,
                                             input logic [MAC_EW-1:0] er,
                                             input logic [MAC_BW-1:0] n,
                                             input logic [MAC_DW-1:0] d);
        return {s, e, er, n, d};
    endfunction

    assign rd       = ov & out_rdy;
    assign full     = (CW'(mcnt) + CW'(ov)) == CW'(DEPTH);
    assign wr       = v0 & ~full;
    assign load_out = ~ov | rd;
    assign bypass   = load_out & (mcnt == '0) & wr;
    assign mw       = wr & ~bypass;
    assign mr       = load_out & (mcnt != '0);
    // Words already owed to the FIFO, including the close pipeline, net of this cycle's read
    assign proj     = CW'(mcnt) + CW'(ov) + CW'(v0) + CW'(v1) - CW'(rd);

    always_comb begin
        nxt_state = state;
        nxt_lane  = lane;
        nxt_acc   = acc;
        nxt_err   = err_acc;
        nxt_sopp  = sopp;
        va = 1'b0; vb = 1'b0; na = '0; nb = '0;
        ovr = 1'b0; drp_add = 2'd0; frm_add = 1'b0; start = 1'b0;
        cur_dat = acc;
        for (int i = 0; i < LANES; i++)
            if (lane == MAC_BW'(i)) cur_dat[MAC_DW-1-i*DAT_DW -: DAT_DW] = rx_idat;
        sop_dat = '0;
        sop_dat[MAC_DW-1 -: DAT_DW] = rx_idat;
        new_err = err_acc | rx_ierr;
        if (rx_ivld) begin
            case (state)
                IDLE: start = rx_isop;
                PACK: begin
                    if (rx_isop) begin
                        // Truncated frame: flush what we hold as an aborted eop word
                        va = 1'b1;
                        na = mkword(sopp, 1'b1, {1'b1, err_acc},
                                    (lane == '0) ? '0 : lane - MAC_BW'(1),
                                    (lane == '0) ? '0 : acc);
                        ovr = 1'b1; drp_add = 2'd1; start = 1'b1;
                    end else if (rx_ieop || lane == MAC_BW'(LANES-1)) begin
                        nxt_acc = '0; nxt_lane = '0; nxt_err = new_err;
                        nxt_state = rx_ieop ? IDLE : PACK;
                        if (proj <= CW'(DEPTH-2)) begin
                            va = 1'b1;
                            na = mkword(sopp, rx_ieop, rx_ieop ? {1'b0, new_err} : '0, lane, cur_dat);
                            frm_add = rx_ieop; nxt_sopp = 1'b0;
                        end else begin
                            ovr = 1'b1; drp_add = 2'd1;
                            if (!rx_ieop) nxt_state = DROP;
                            // Once the sop word is out the consumer must see a terminator
                            if (!sopp) begin
                                va = 1'b1;
                                na = mkword(1'b0, 1'b1, {1'b1, new_err}, '0, '0);
                            end
                        end
                    end else begin
                        nxt_acc = cur_dat; nxt_lane = lane + MAC_BW'(1); nxt_err = new_err;
                    end
                end
                DROP: if (rx_ieop) nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
            if (start) begin
                nxt_acc = '0; nxt_lane = '0; nxt_err = rx_ierr; nxt_sopp = 1'b1;
                if (!upact) begin
                    drp_add = drp_add + 2'd1;
                    nxt_state = rx_ieop ? IDLE : DROP;
                end else if (rx_ieop) begin
                    nxt_state = IDLE;
                    if (proj + CW'(va) <= CW'(DEPTH-2)) begin
                        vb = 1'b1; frm_add = 1'b1;
                        nb = mkword(1'b1, 1'b1, {1'b0, rx_ierr}, '0, sop_dat);
                    end else begin
                        ovr = 1'b1; drp_add = drp_add + 2'd1;
                    end
                end else begin
                    nxt_acc = sop_dat; nxt_lane = MAC_BW'(1); nxt_state = PACK;
                end
            end
        end
    end

    always_ff @(posedge rxclk or negedge rxrst_) begin
        if (!rxrst_) begin
            state <= IDLE; lane <= '0; acc <= '0; err_acc <= '0; sopp <= 1'b0;
            p0 <= '0; p1 <= '0; v0 <= 1'b0; v1 <= 1'b0; ovrerr <= 1'b0;
        end else begin
            state <= nxt_state; lane <= nxt_lane; acc <= nxt_acc;
            err_acc <= nxt_err; sopp <= nxt_sopp; ovrerr <= ovr;
            // Two-entry close queue: a truncation can close two words in one cycle
            if (v1) begin
                p0 <= p1; v0 <= 1'b1; p1 <= va ? na : nb; v1 <= va | vb;
            end else if (va) begin
                p0 <= na; v0 <= 1'b1; p1 <= nb; v1 <= vb;
            end else begin
                p0 <= nb; v0 <= vb; v1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge rxclk) begin
        if (mw) mem[wp] <= p0;
    end

    always_ff @(posedge rxclk or negedge rxrst_) begin
        if (!rxrst_) begin
            wp <= '0; rp <= '0; mcnt <= '0; ov <= 1'b0; od <= '0;
        end else begin
            if (load_out) begin
                if (mr) begin
                    od <= mem[rp]; ov <= 1'b1; rp <= rp + FIFO_AW'(1);
                end else if (wr) begin
                    od <= p0; ov <= 1'b1;
                end else begin
                    od <= '0; ov <= 1'b0;
                end
            end
            if (mw) wp <= wp + FIFO_AW'(1);
            mcnt <= mcnt + {FIFO_AW'(0), mw} - {FIFO_AW'(0), mr};
        end
    end

    assign {out_sop, out_eop, out_err, out_nob, out_dat} = od;
    assign out_vld = ov;

`ifdef IPSMACGE_RXPACKN_STAT_EN
    logic [15:0] frm_q, drp_q;
    logic [16:0] frm_sum, drp_sum;
    assign frm_sum = {1'b0, frm_q} + 17'(frm_add);
    assign drp_sum = {1'b0, drp_q} + 17'(drp_add);
    always_ff @(posedge rxclk or negedge rxrst_) begin
        if (!rxrst_) begin
            frm_q <= '0; drp_q <= '0;
        end else begin
            frm_q <= frm_sum[16] ? 16'hFFFF : frm_sum[15:0];
            drp_q <= drp_sum[16] ? 16'hFFFF : drp_sum[15:0];
        end
    end
    assign frm_cnt = frm_q;
    assign drp_cnt = drp_q;
`else
    logic unused_stat;
    assign unused_stat = ^{frm_add, drp_add};
    assign frm_cnt = '0;
    assign drp_cnt = '0;
`endif
endmodule

// File: tb/tb_ipsmacge_rxpackn.sv
// tb/tb_ipsmacge_rxpackn.sv - scoreboard bench for the rx packer, 32-bit and 64-bit builds
`timescale 1ns/1ps
module tb_ipsmacge_rxpackn;
    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IPSMACGE_RXPACKN_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        rst_n, isop, ieop, upact, a_ivld, b_ivld, a_rdy, b_rdy;
    logic [7:0]  idat;
    logic [3:0]  ierr;
    logic [31:0] a_dat;
    logic [1:0]  a_nob;
    logic        a_vld, a_sop, a_eop, a_ovr;
    logic [4:0]  a_err;
    logic [15:0] a_frm, a_drp;
    logic [63:0] b_dat;
    logic [2:0]  b_nob;
    logic        b_vld, b_sop, b_eop, b_ovr;
    logic [4:0]  b_err;
    logic [15:0] b_frm, b_drp;

    ipsmacge_rxpackn u_a (
        .rxclk(clk), .rxrst_(rst_n), .rx_idat(idat), .rx_ivld(a_ivld), .rx_isop(isop),
        .rx_ieop(ieop), .rx_ierr(ierr), .upact(upact), .out_dat(a_dat), .out_nob(a_nob),
        .out_vld(a_vld), .out_rdy(a_rdy), .out_sop(a_sop), .out_eop(a_eop), .out_err(a_err),
        .ovrerr(a_ovr), .frm_cnt(a_frm), .drp_cnt(a_drp)
    );

    ipsmacge_rxpackn #(.MAC_DW(64), .MAC_BW(3)) u_b (
        .rxclk(clk), .rxrst_(rst_n), .rx_idat(idat), .rx_ivld(b_ivld), .rx_isop(isop),
        .rx_ieop(ieop), .rx_ierr(ierr), .upact(upact), .out_dat(b_dat), .out_nob(b_nob),
        .out_vld(b_vld), .out_rdy(b_rdy), .out_sop(b_sop), .out_eop(b_eop), .out_err(b_err),
        .ovrerr(b_ovr), .frm_cnt(b_frm), .drp_cnt(b_drp)
    );

    typedef struct {
        logic [63:0] dat;
        logic [2:0]  nob;
        logic        sop;
        logic        eop;
        logic [4:0]  err;
    } exp_t;

    exp_t qa[$], qb[$];
    int checks = 0, errors = 0, a_ovr_cnt = 0, b_ovr_cnt = 0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_ovr === 1'b1) a_ovr_cnt++;
        if (rst_n === 1'b1 && a_vld === 1'b1 && a_rdy === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_word_unexpected: got dat=%h nob=%0d sop=%b eop=%b err=%h, required no word",
                         a_dat, a_nob, a_sop, a_eop, a_err);
            end else begin
                e = qa.pop_front();
                if ({a_dat, a_nob, a_sop, a_eop, a_err} !== {e.dat[31:0], e.nob[1:0], e.sop, e.eop, e.err}) begin
                    errors++;
                    $display("FAIL a_word: got dat=%h nob=%0d sop=%b eop=%b err=%h, required dat=%h nob=%0d sop=%b eop=%b err=%h",
                             a_dat, a_nob, a_sop, a_eop, a_err, e.dat[31:0], e.nob[1:0], e.sop, e.eop, e.err);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_ovr === 1'b1) b_ovr_cnt++;
        if (rst_n === 1'b1 && b_vld === 1'b1 && b_rdy === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_word_unexpected: got dat=%h nob=%0d sop=%b eop=%b err=%h, required no word",
                         b_dat, b_nob, b_sop, b_eop, b_err);
            end else begin
                e = qb.pop_front();
                if ({b_dat, b_nob, b_sop, b_eop, b_err} !== {e.dat, e.nob, e.sop, e.eop, e.err}) begin
                    errors++;
                    $display("FAIL b_word: got dat=%h nob=%0d sop=%b eop=%b err=%h, required dat=%h nob=%0d sop=%b eop=%b err=%h",
                             b_dat, b_nob, b_sop, b_eop, b_err, e.dat, e.nob, e.sop, e.eop, e.err);
                end
            end
        end
    end

    task automatic send_sym(input bit to_b, input logic [7:0] d, input bit s, input bit e, input logic [3:0] er);
        idat = d; isop = s; ieop = e; ierr = er;
        if (to_b) b_ivld = 1'b1; else a_ivld = 1'b1;
        @(posedge clk); #1;
        a_ivld = 1'b0; b_ivld = 1'b0; isop = 1'b0; ieop = 1'b0; ierr = 4'h0;
    endtask

    task automatic push_exp(input bit to_b, input logic [63:0] d, input int n, input bit s, input bit e, input logic [4:0] er);
        exp_t x;
        x.dat = d; x.nob = 3'(n); x.sop = s; x.eop = e; x.err = er;
        if (to_b) qb.push_back(x); else qa.push_back(x);
    endtask

    // Model: bytes base, base+1, ... packed first-byte-in-MSB lanes
    task automatic send_frame(input bit to_b, input int n, input logic [7:0] base, input logic [3:0] er);
        int lanes = to_b ? 8 : 4;
        for (int w = 0; w * lanes < n; w++) begin
            logic [63:0] d = '0;
            logic [7:0]  bv;
            int nb = (n - w * lanes < lanes) ? n - w * lanes : lanes;
            bit last = ((w + 1) * lanes >= n);
            for (int k = 0; k < nb; k++) begin
                bv = base + 8'(w * lanes + k);
                d = d | (64'(bv) << ((lanes - 1 - k) * 8));
            end
            push_exp(to_b, d, nb - 1, w == 0, last, last ? {1'b0, er} : 5'h00);
        end
        for (int i = 0; i < n; i++)
            send_sym(to_b, base + 8'(i), i == 0, i == n - 1, (i == n - 1) ? er : 4'h0);
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idat = 8'h00; isop = 1'b0; ieop = 1'b0; ierr = 4'h0; upact = 1'b1;
        a_ivld = 1'b0; b_ivld = 1'b0; a_rdy = 1'b1; b_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_vld, a_dat, a_nob, a_sop, a_eop, a_err, a_ovr, a_frm, a_drp} !== '0) begin
            errors++;
            $display("FAIL reset_a: got vld=%b dat=%h ovr=%b frm=%0d drp=%0d, required all zero", a_vld, a_dat, a_ovr, a_frm, a_drp);
        end
        checks++;
        if ({b_vld, b_dat, b_nob, b_sop, b_eop, b_err, b_ovr, b_frm, b_drp} !== '0) begin
            errors++;
            $display("FAIL reset_b: got vld=%b dat=%h ovr=%b frm=%0d drp=%0d, required all zero", b_vld, b_dat, b_ovr, b_frm, b_drp);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok;
        int o0 = a_ovr_cnt;
        logic [15:0] f0 = a_frm;
        send_frame(1'b0, 6, 8'h01, 4'h0);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_drain: got %0d words pending, required 0", qa.size()); end
        checks++;
        if (a_ovr_cnt - o0 != 0) begin errors++; $display("FAIL basic_ovrerr: got %0d pulses, required 0", a_ovr_cnt - o0); end
        checks++;
        if (a_frm !== (STAT ? f0 + 16'd1 : 16'd0)) begin
            errors++; $display("FAIL basic_frm_cnt: got %0d, required %0d", a_frm, STAT ? f0 + 16'd1 : 16'd0);
        end
    endtask

    task automatic test_single_latency();
        bit ok;
        send_frame(1'b0, 1, 8'hAA, 4'h2);
        @(negedge clk);
        checks++;
        if (a_vld !== 1'b0) begin errors++; $display("FAIL latency_early: got out_vld=%b, required 0", a_vld); end
        @(negedge clk);
        checks++;
        if (a_vld !== 1'b1) begin errors++; $display("FAIL latency_due: got out_vld=%b, required 1", a_vld); end
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_drain: got %0d words pending, required 0", qa.size()); end
    endtask

    task automatic test_upact();
        int seen = 0;
        int o0 = a_ovr_cnt;
        logic [15:0] d0 = a_drp;
        upact = 1'b0;
        send_sym(1'b0, 8'h11, 1'b1, 1'b0, 4'h0);
        send_sym(1'b0, 8'h12, 1'b0, 1'b0, 4'h0);
        upact = 1'b1;
        for (int i = 0; i < 4; i++) send_sym(1'b0, 8'h13 + 8'(i), 1'b0, i == 3, 4'h0);
        repeat (8) begin @(negedge clk); if (a_vld === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL upact_words: got %0d valid cycles, required 0", seen); end
        checks++;
        if (a_ovr_cnt - o0 != 0) begin errors++; $display("FAIL upact_ovrerr: got %0d pulses, required 0", a_ovr_cnt - o0); end
        checks++;
        if (a_drp !== (STAT ? d0 + 16'd1 : 16'd0)) begin
            errors++; $display("FAIL upact_drp_cnt: got %0d, required %0d", a_drp, STAT ? d0 + 16'd1 : 16'd0);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int o0 = a_ovr_cnt;
        logic [15:0] d0 = a_drp;
        @(posedge clk); #1;
        a_rdy = 1'b0;
        for (int w = 0; w < 7; w++) begin
            logic [31:0] d;
            for (int k = 0; k < 4; k++) d[31 - 8*k -: 8] = 8'(4*w + k + 1);
            push_exp(1'b0, {32'h0, d}, 3, w == 0, 1'b0, 5'h00);
        end
        push_exp(1'b0, 64'h0, 0, 1'b0, 1'b1, 5'h10);
        for (int i = 0; i < 40; i++) send_sym(1'b0, 8'(i + 1), i == 0, i == 39, 4'h0);
        repeat (4) @(negedge clk);
        checks++;
        if (a_ovr_cnt - o0 != 1) begin errors++; $display("FAIL overflow_ovrerr: got %0d pulses, required 1", a_ovr_cnt - o0); end
        checks++;
        if (a_vld !== 1'b1) begin errors++; $display("FAIL overflow_held: got out_vld=%b, required 1", a_vld); end
        checks++;
        if (a_drp !== (STAT ? d0 + 16'd1 : 16'd0)) begin
            errors++; $display("FAIL overflow_drp_cnt: got %0d, required %0d", a_drp, STAT ? d0 + 16'd1 : 16'd0);
        end
        @(posedge clk); #1;
        a_rdy = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL overflow_drain: got %0d words pending, required 0", qa.size()); end
    endtask

    task automatic test_truncation();
        bit ok;
        int o0 = a_ovr_cnt;
        push_exp(1'b0, 64'h21222324, 3, 1'b1, 1'b0, 5'h00);
        push_exp(1'b0, 64'h25000000, 0, 1'b0, 1'b1, 5'h10);
        for (int i = 0; i < 5; i++) send_sym(1'b0, 8'h21 + 8'(i), i == 0, 1'b0, 4'h0);
        send_frame(1'b0, 3, 8'h31, 4'h0);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL trunc_drain: got %0d words pending, required 0", qa.size()); end
        checks++;
        if (a_ovr_cnt - o0 != 1) begin errors++; $display("FAIL trunc_ovrerr: got %0d pulses, required 1", a_ovr_cnt - o0); end
    endtask

    task automatic test_wide();
        bit ok;
        logic [15:0] f0 = b_frm;
        send_frame(1'b1, 13, 8'h41, 4'h0);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wide_drain: got %0d words pending, required 0", qb.size()); end
        checks++;
        if (b_frm !== (STAT ? f0 + 16'd1 : 16'd0)) begin
            errors++; $display("FAIL wide_frm_cnt: got %0d, required %0d", b_frm, STAT ? f0 + 16'd1 : 16'd0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int o0 = a_ovr_cnt;
        logic [15:0] f0 = a_frm;
        for (int f = 0; f < 8; f++)
            send_frame(1'b0, (f < 2) ? 1 : int'($urandom_range(1, 9)), 8'($urandom_range(0, 255)),
                       4'($urandom_range(0, 15)));
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain: got %0d words pending, required 0", qa.size()); end
        checks++;
        if (a_ovr_cnt - o0 != 0) begin errors++; $display("FAIL b2b_ovrerr: got %0d pulses, required 0", a_ovr_cnt - o0); end
        checks++;
        if (a_frm !== (STAT ? f0 + 16'd8 : 16'd0)) begin
            errors++; $display("FAIL b2b_frm_cnt: got %0d, required %0d", a_frm, STAT ? f0 + 16'd8 : 16'd0);
        end
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        a_rdy = 1'b0;
        for (int i = 0; i < 6; i++) send_sym(1'b0, 8'h61 + 8'(i), i == 0, 1'b0, 4'h0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (a_vld !== 1'b0) begin errors++; $display("FAIL midrst_vld: got out_vld=%b, required 0", a_vld); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_rdy = 1'b1;
        repeat (10) begin @(negedge clk); if (a_vld === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midrst_words: got %0d valid cycles, required 0", seen); end
        checks++;
        if ({a_frm, a_drp} !== 32'h0) begin errors++; $display("FAIL midrst_cnt: got frm=%0d drp=%0d, required 0 0", a_frm, a_drp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_latency();
        test_upact();
        test_overflow();
        test_truncation();
        test_wide();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout at %0t, required completion", $time);
        $fatal(1);
    end
endmodule
